// File: rtl/range_frame_sequencer_pkg.sv
// rtl/range_frame_sequencer_pkg.sv - shared state encodings and sizing helpers for the frame sequencer
package range_frame_sequencer_pkg;

  // Replay FSM states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EMIT_FIRST = 2'd1,
    ST_EMIT       = 2'd2,
    ST_GAP        = 2'd3
  } rfseq_state_t;

  // FIFO entry is {last, data}
  function automatic int unsigned entry_width(input int unsigned width);
    return width + 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/range_frame_sequencer_fifo.sv
// rtl/range_frame_sequencer_fifo.sv - synchronous FIFO of {last,data} entries with force-last on newest entry
module rf_sync_fifo
  import range_frame_sequencer_pkg::*;
#(
  parameter int unsigned DW    = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  input  logic                       force_last,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_newest_ptr;

  // A push into a full FIFO is only accepted when a pop frees the slot the same cycle
  assign w_wr         = push & (~full | pop);
  assign w_rd         = pop & ~empty;
  assign w_newest_ptr = r_wr_ptr - AW'(1);

  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; force_last closes the frame held in the most recently written slot
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= wdata;
    if (force_last) r_mem[w_newest_ptr][DW-1] <= 1'b1;
  end

endmodule

// File: rtl/range_frame_sequencer.sv
// rtl/range_frame_sequencer.sv - buffers whole frames and replays them as go/data/finish; RFSEQ_STATS_EN enables frame_count
module range_frame_sequencer
  import range_frame_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_in,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             truncated,
  output logic [7:0]       frame_count
);

  localparam int unsigned EW = entry_width(WIDTH);
  localparam int unsigned PW = count_width(DEPTH);
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

  rfseq_state_t     r_state;
  rfseq_state_t     w_next_state;

  logic [PW-1:0]    r_pending;
  logic             r_ready_en;
  logic [WIDTH-1:0] r_data;
  logic             r_go;
  logic             r_finish;
  logic             r_truncated;

  logic [EW-1:0]    w_head;
  logic             w_head_last;
  logic [WIDTH-1:0] w_head_data;
  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_force;
  logic             w_pend_inc;
  logic             w_pend_dec;
  logic             w_load;
  logic             w_go_d;
  logic             w_finish_d;

  assign w_head_last = w_head[EW-1];
  assign w_head_data = w_head[WIDTH-1:0];
  assign in_ready    = r_ready_en & ~w_full;
  assign w_push      = in_valid & in_ready;

  // A full FIFO holding no complete frame can never drain, so close the open frame
  assign w_force    = (w_count == FULL_COUNT) & (r_pending == '0);
  assign w_pend_inc = (w_push & in_last) | w_force;
  assign w_pend_dec = w_pop & w_head_last;

  rf_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .wdata      ({in_last, in_data}),
    .pop        (w_pop),
    .force_last (w_force),
    .rdata      (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  // Input side opens one edge after reset is released
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ready_en <= 1'b0;
    else       r_ready_en <= 1'b1;
  end

  // Complete frames currently buffered, plus the sticky truncation flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending   <= '0;
      r_truncated <= 1'b0;
    end else begin
      case ({w_pend_inc, w_pend_dec})
        2'b10:   r_pending <= r_pending + PW'(1);
        2'b01:   r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
      if (w_force) r_truncated <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:       if (r_pending != '0) w_next_state = ST_EMIT_FIRST;
      ST_EMIT_FIRST: w_next_state = ST_EMIT;
      ST_EMIT:       if (w_head_last) w_next_state = ST_GAP;
      ST_GAP:        w_next_state = (r_pending != '0) ? ST_EMIT_FIRST : ST_IDLE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: a 1-sample frame is left in place by EMIT_FIRST so EMIT replays it with finish
  always_comb begin
    w_pop      = 1'b0;
    w_load     = 1'b0;
    w_go_d     = 1'b0;
    w_finish_d = 1'b0;
    case (r_state)
      ST_EMIT_FIRST: begin
        w_load = 1'b1;
        w_go_d = 1'b1;
        w_pop  = ~w_head_last & ~w_empty;
      end
      ST_EMIT: begin
        w_load     = 1'b1;
        w_finish_d = w_head_last;
        w_pop      = ~w_empty;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Registered stream towards RangeFinder; data holds between frames
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_go     <= w_go_d;
      r_finish <= w_finish_d;
      if (w_load) r_data <= w_head_data;
    end
  end

  assign data_in   = r_data;
  assign go        = r_go;
  assign finish    = r_finish;
  assign busy      = (r_state != ST_IDLE);
  assign truncated = r_truncated;

`ifdef RFSEQ_STATS_EN
  logic [7:0] r_frame_count;

  // Count every cycle that presents a frame's final sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_frame_count <= 8'd0;
    else if (r_finish) r_frame_count <= r_frame_count + 8'd1;
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 8'd0;
`endif

endmodule
